// File: rtl/noc_alloc_pkg.sv
// Shared types and constants for the crossbar switch allocator.
package noc_alloc_pkg;

  typedef enum logic {
    FREE     = 1'b0,
    RESERVED = 1'b1
  } out_state_e;

  localparam int WATCHDOG_CYCLES_DEFAULT = 1024;

  // Width of an index into n items, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/ownership bundle between input ports and the switch allocator.
// The watchdogExpired member exists only when ALLOC_WATCHDOG_EN is defined.
interface switch_allocator_if
  import noc_alloc_pkg::*;
#(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = safe_clog2(OUTPUTS),
  parameter int SEL_WIDTH     = safe_clog2(INPUTS)
);
  logic [INPUTS-1:0]                routeReserveRequestValid;
  logic [INPUTS*REQUEST_WIDTH-1:0]  routeReserveRequest;
  logic [INPUTS-1:0]                routeRelieve;
  logic [INPUTS-1:0]                routeReserveStatus;
  logic [OUTPUTS*SEL_WIDTH-1:0]     outOwner;
  logic [OUTPUTS-1:0]               outBusy;
  logic [INPUTS-1:0]                badRequest;
`ifdef ALLOC_WATCHDOG_EN
  logic [OUTPUTS-1:0]               watchdogExpired;
`endif

  modport master (
    output routeReserveRequestValid, routeReserveRequest, routeRelieve,
    input  routeReserveStatus, outOwner, outBusy, badRequest
`ifdef ALLOC_WATCHDOG_EN
    , input watchdogExpired
`endif
  );

  modport slave (
    input  routeReserveRequestValid, routeReserveRequest, routeRelieve,
    output routeReserveStatus, outOwner, outBusy, badRequest
`ifdef ALLOC_WATCHDOG_EN
    , output watchdogExpired
`endif
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer with wrap-around, grants the first
// requester and moves the pointer just past the winner.
module rr_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = safe_clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] scan_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (!grant_valid && req[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        grant_valid     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (grant_valid) begin
      ptr_q <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Per-output reservation allocator driving crossbar owner selects.
// Optional forced-release watchdog is built when ALLOC_WATCHDOG_EN is defined.
//
// state    | meaning
// FREE     | output unowned; arbitrates eligible requests this cycle
// RESERVED | held by owner_q until the owner relieves (or the watchdog expires)
module switch_allocator
  import noc_alloc_pkg::*;
#(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = safe_clog2(OUTPUTS),
  parameter int SEL_WIDTH     = safe_clog2(INPUTS)
`ifdef ALLOC_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  switch_allocator_if.slave bus
);
  out_state_e               state_q [OUTPUTS];
  out_state_e               state_d [OUTPUTS];
  logic [SEL_WIDTH-1:0]     owner_q [OUTPUTS];
  logic [SEL_WIDTH-1:0]     owner_d [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] req_idx [INPUTS];
  logic [INPUTS-1:0]        in_range, eligible, status, bad_q;
  logic [INPUTS-1:0]        arb_req   [OUTPUTS];
  logic [INPUTS-1:0]        arb_grant [OUTPUTS];
  logic [SEL_WIDTH-1:0]     arb_idx   [OUTPUTS];
  logic [OUTPUTS-1:0]       arb_valid, relieve_hit, wd_expire;

  // An owner is never eligible, so a same-cycle relieve+request from it is ignored.
  always_comb begin
    in_range    = '0;
    eligible    = '0;
    relieve_hit = '0;
    for (int i = 0; i < INPUTS; i++) begin
      req_idx[i]  = bus.routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      in_range[i] = int'(req_idx[i]) < OUTPUTS;
      eligible[i] = bus.routeReserveRequestValid[i] && !status[i] && in_range[i];
    end
    for (int o = 0; o < OUTPUTS; o++) begin
      arb_req[o] = '0;
      for (int i = 0; i < INPUTS; i++)
        arb_req[o][i] = eligible[i] && (state_q[o] == FREE) && (int'(req_idx[i]) == o);
      relieve_hit[o] = (state_q[o] == RESERVED) && bus.routeRelieve[owner_q[o]];
    end
  end

  for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
    rr_arbiter #(.N(INPUTS), .IW(SEL_WIDTH)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (arb_req[o]),
      .grant      (arb_grant[o]),
      .grant_idx  (arb_idx[o]),
      .grant_valid(arb_valid[o])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= FREE;
        owner_q[o] <= '0;
      end
      bad_q <= '0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
      end
      bad_q <= bus.routeReserveRequestValid & ~in_range;
    end
  end

  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      case (state_q[o])
        FREE: begin
          if (arb_valid[o]) begin
            state_d[o] = RESERVED;
            owner_d[o] = arb_idx[o];
          end
        end
        RESERVED: begin
          if (relieve_hit[o] || wd_expire[o]) begin
            state_d[o] = FREE;
            owner_d[o] = '0;
          end
        end
        default: begin
          state_d[o] = FREE;
          owner_d[o] = '0;
        end
      endcase
    end
  end

  always_comb begin
    status          = '0;
    bus.outBusy     = '0;
    bus.outOwner    = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      bus.outBusy[o] = (state_q[o] == RESERVED);
      bus.outOwner[o*SEL_WIDTH +: SEL_WIDTH] = owner_q[o];
      for (int i = 0; i < INPUTS; i++)
        if ((state_q[o] == RESERVED) && (owner_q[o] == SEL_WIDTH'(i)))
          status[i] = 1'b1;
    end
    bus.routeReserveStatus = status;
  end

  assign bus.badRequest = bad_q;

`ifdef ALLOC_WATCHDOG_EN
  localparam int WD_W = safe_clog2(WATCHDOG_CYCLES);
  logic [WD_W-1:0]    wd_cnt_q [OUTPUTS];
  logic [OUTPUTS-1:0] wd_pulse_q;

  // A relieve in the expiry cycle wins, so no pulse is raised for it.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++)
      wd_expire[o] = (state_q[o] == RESERVED) && !relieve_hit[o] &&
                     (wd_cnt_q[o] == WD_W'(WATCHDOG_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < OUTPUTS; o++) wd_cnt_q[o] <= '0;
      wd_pulse_q <= '0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++)
        wd_cnt_q[o] <= (state_q[o] == RESERVED) ? wd_cnt_q[o] + 1'b1 : '0;
      wd_pulse_q <= wd_expire;
    end
  end

  assign bus.watchdogExpired = wd_pulse_q;
`else
  assign wd_expire = '0;
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator (4x4 main instance, 3x3 for range checks).
module tb_switch_allocator;
  import noc_alloc_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb[$];
  int   rr_order[4] = '{0, 1, 3, 0};

  always #5 clk = ~clk;

  switch_allocator_if #(.INPUTS(4), .OUTPUTS(4)) bus_a ();
  switch_allocator_if #(.INPUTS(3), .OUTPUTS(3)) bus_b ();

  switch_allocator #(
    .INPUTS(4), .OUTPUTS(4)
`ifdef ALLOC_WATCHDOG_EN
    , .WATCHDOG_CYCLES(8)
`endif
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  switch_allocator #(.INPUTS(3), .OUTPUTS(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic logic [31:0] mk_a(input logic [3:0] bad, input logic [3:0] st,
                                       input logic [3:0] busy, input logic [7:0] own);
    return {12'b0, bad, st, busy, own};
  endfunction

  function automatic logic [31:0] mk_b(input logic [2:0] bad, input logic [2:0] st,
                                       input logic [2:0] busy, input logic [5:0] own);
    return {17'b0, bad, st, busy, own};
  endfunction

  function automatic logic [31:0] snap_a();
    return {12'b0, bus_a.badRequest, bus_a.routeReserveStatus, bus_a.outBusy, bus_a.outOwner};
  endfunction

  function automatic logic [31:0] snap_b();
    return {17'b0, bus_b.badRequest, bus_b.routeReserveStatus, bus_b.outBusy, bus_b.outOwner};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.routeReserveRequestValid = '0;
    bus_a.routeReserveRequest      = '0;
    bus_a.routeRelieve             = '0;
    bus_b.routeReserveRequestValid = '0;
    bus_b.routeReserveRequest      = '0;
    bus_b.routeRelieve             = '0;
    #2;
    push("reset_a", mk_a(4'b0, 4'b0, 4'b0, 8'b0));
    compare(snap_a());
    push("reset_b", mk_b(3'b0, 3'b0, 3'b0, 6'b0));
    compare(snap_b());
    tick();
    rst = 1'b1;
    tick();

    // 3x3 instance: index 3 is out of range for input 1
    bus_b.routeReserveRequestValid = 3'b010;
    bus_b.routeReserveRequest      = 6'b00_11_00;
    push("bad_held1", mk_b(3'b010, 3'b0, 3'b0, 6'b0));
    tick();
    compare(snap_b());
    push("bad_held2", mk_b(3'b010, 3'b0, 3'b0, 6'b0));
    tick();
    compare(snap_b());
    bus_b.routeReserveRequestValid = 3'b000;
    push("bad_clear", mk_b(3'b0, 3'b0, 3'b0, 6'b0));
    tick();
    compare(snap_b());
    bus_b.routeReserveRequestValid = 3'b100;
    bus_b.routeReserveRequest      = 6'b10_00_00;
    push("b_grant", mk_b(3'b0, 3'b100, 3'b100, 6'b10_00_00));
    tick();
    compare(snap_b());
    bus_b.routeReserveRequestValid = 3'b000;
    bus_b.routeRelieve             = 3'b100;
    push("b_relieve", mk_b(3'b0, 3'b0, 3'b0, 6'b0));
    tick();
    compare(snap_b());
    bus_b.routeRelieve = 3'b000;

    // single grant: input 2 -> output 1, then stray relieve, then real relieve
    bus_a.routeReserveRequestValid = 4'b0100;
    bus_a.routeReserveRequest      = 8'b00_01_00_00;
    push("single_grant", mk_a(4'b0, 4'b0100, 4'b0010, 8'b00_00_10_00));
    tick();
    compare(snap_a());
    bus_a.routeReserveRequestValid = 4'b0000;
    bus_a.routeRelieve             = 4'b0001;
    push("stray_relieve", mk_a(4'b0, 4'b0100, 4'b0010, 8'b00_00_10_00));
    tick();
    compare(snap_a());
    bus_a.routeRelieve = 4'b0100;
    push("single_relieve", mk_a(4'b0, 4'b0, 4'b0, 8'b0));
    tick();
    compare(snap_a());
    bus_a.routeRelieve = 4'b0000;

    // round robin on output 0; requests stay asserted through each relieve
    bus_a.routeReserveRequestValid = 4'b1011;
    bus_a.routeReserveRequest      = 8'b0;
    for (int g = 0; g < 4; g++) begin
      push($sformatf("rr_grant%0d", g),
           mk_a(4'b0, 4'(1 << rr_order[g]), 4'b0001, 8'(rr_order[g])));
      tick();
      compare(snap_a());
      bus_a.routeRelieve = 4'(1 << rr_order[g]);
      push($sformatf("rr_idle%0d", g), mk_a(4'b0, 4'b0, 4'b0, 8'b0));
      tick();
      compare(snap_a());
      bus_a.routeRelieve = 4'b0000;
    end
    bus_a.routeReserveRequestValid = 4'b0000;

    // parallel grants: inputs 0..3 -> outputs 3..0
    bus_a.routeReserveRequestValid = 4'b1111;
    bus_a.routeReserveRequest      = 8'b00_01_10_11;
    push("parallel", mk_a(4'b0, 4'b1111, 4'b1111, 8'b00_01_10_11));
    tick();
    compare(snap_a());
    bus_a.routeReserveRequestValid = 4'b0000;
    bus_a.routeRelieve             = 4'b0101;
    push("partial_relieve", mk_a(4'b0, 4'b1010, 4'b0101, 8'b00_01_00_11));
    tick();
    compare(snap_a());
    bus_a.routeRelieve = 4'b0000;

    // asynchronous reset while outputs 0 and 2 are reserved
    #3;
    rst = 1'b0;
    #1;
    push("async_reset", mk_a(4'b0, 4'b0, 4'b0, 8'b0));
    compare(snap_a());
    #2;
    rst = 1'b1;
    // output 2 pointer was 2 before reset; restart at 0 must pick input 0 over 3
    bus_a.routeReserveRequestValid = 4'b1001;
    bus_a.routeReserveRequest      = 8'b10_00_00_10;
    push("ptr_restart", mk_a(4'b0, 4'b0001, 4'b0100, 8'b0));
    tick();
    compare(snap_a());
    bus_a.routeReserveRequestValid = 4'b0000;
    bus_a.routeRelieve             = 4'b0001;
    push("ptr_relieve", mk_a(4'b0, 4'b0, 4'b0, 8'b0));
    tick();
    compare(snap_a());
    bus_a.routeRelieve = 4'b0000;

`ifdef ALLOC_WATCHDOG_EN
    bus_a.routeReserveRequestValid = 4'b0010;
    bus_a.routeReserveRequest      = 8'b00_10_00_00;
    push("wd_grant", mk_a(4'b0, 4'b0010, 4'b0100, 8'b00_01_00_00));
    tick();
    compare(snap_a());
    bus_a.routeReserveRequestValid = 4'b0000;
    repeat (7) tick();
    push("wd_hold", mk_a(4'b0, 4'b0010, 4'b0100, 8'b00_01_00_00));
    compare(snap_a());
    push("wd_hold_pulse", 32'h0);
    compare({28'b0, bus_a.watchdogExpired});
    tick();
    push("wd_release", mk_a(4'b0, 4'b0, 4'b0, 8'b0));
    compare(snap_a());
    push("wd_pulse", 32'h4);
    compare({28'b0, bus_a.watchdogExpired});
    tick();
    push("wd_pulse_end", 32'h0);
    compare({28'b0, bus_a.watchdogExpired});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
